data_mem_arb: RTL

DATA_MEM_ARB -- requirements
Module: data_mem_arb

---
 rtl/data_mem_arb_if.sv | 17 +
 rtl/data_mem_arb.sv | 57 +++++
 2 files changed

// File: rtl/data_mem_arb_if.sv
// data_mem_arb_if: two requester ports and the data-memory bus of data_mem_arb
interface data_mem_arb_if;
  logic        a_req, a_wr, a_ack, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_wr, b_ack, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        mem_wr;
  logic [31:0] addr, data_input, data_output;
  modport master (
    output a_req, a_wr, a_addr, a_wdata, b_req, b_wr, b_addr, b_wdata, data_output,
    input  a_ack, a_rdata, a_err, b_ack, b_rdata, b_err, mem_wr, addr, data_input
  );
  modport slave (
    input  a_req, a_wr, a_addr, a_wdata, b_req, b_wr, b_addr, b_wdata, data_output,
    output a_ack, a_rdata, a_err, b_ack, b_rdata, b_err, mem_wr, addr, data_input
  );
endinterface

// File: rtl/data_mem_arb.sv
// data_mem_arb: two-port arbiter in front of a single-port data memory, fixed 3-cycle access
module data_mem_arb #(
  parameter int ADDR_LIMIT = 32,
  parameter bit RR_EN      = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           run,
  data_mem_arb_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  logic [1:0]  state;
  logic        l_wr, l_id, last_b, grant_b, in_range;
  logic [31:0] l_addr, l_wdata, rd;
  // l_id/last_b: 1 means port B; B wins a round-robin tie only if A was served last
  assign grant_b        = bus.b_req && (!bus.a_req || (RR_EN && !last_b));
  assign in_range       = l_addr < 32'(ADDR_LIMIT);
  assign rd             = in_range ? bus.data_output : '0;
  assign bus.mem_wr     = state == ACCESS && l_wr && in_range;
  assign bus.addr       = l_addr;
  assign bus.data_input = l_wdata;
  assign bus.a_ack      = state == RESP && !l_id;
  assign bus.b_ack      = state == RESP && l_id;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      l_wr        <= 1'b0;
      l_id        <= 1'b0;
      last_b      <= 1'b0;
      l_addr      <= '0;
      l_wdata     <= '0;
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
      bus.a_err   <= 1'b0;
      bus.b_err   <= 1'b0;
    end else if (state == IDLE) begin
      if (run && (bus.a_req || bus.b_req)) begin
        state   <= ACCESS;
        l_id    <= grant_b;
        l_wr    <= grant_b ? bus.b_wr : bus.a_wr;
        l_addr  <= grant_b ? bus.b_addr : bus.a_addr;
        l_wdata <= grant_b ? bus.b_wdata : bus.a_wdata;
      end
    end else if (state == ACCESS) begin
      state <= RESP;
      if (l_id) begin
        bus.b_rdata <= rd;
        bus.b_err   <= !in_range;
      end else begin
        bus.a_rdata <= rd;
        bus.a_err   <= !in_range;
      end
    end else begin
      state  <= IDLE;
      last_b <= l_id;
    end
endmodule
